// File: rtl/cordic_seq_pkg.sv
// Shared constants for the CORDIC pipelined-unit sequencer: opcodes, FSM
// states and the bit that flags a dropped PUSH.
package cordic_seq_pkg;

    typedef enum logic [1:0] {
        OP_PUSH   = 2'd0,
        OP_RUN    = 2'd1,
        OP_STATUS = 2'd2,
        OP_FLUSH  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int unsigned OVF_BIT = 31;

    // Result words only ever carry the low six bits of the fill count.
    function automatic logic [31:0] count_word(input logic [6:0] cnt);
        return {26'b0, cnt[5:0]};
    endfunction

endpackage

// File: rtl/cordic_ppl_sequencer_if.sv
// Sample-buffer bus between the sequencer (master) and its FIFO (slave).
interface cordic_ppl_sequencer_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
);
    logic          en;
    logic          wr_en;
    logic          rd_en;
    logic          flush;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    modport master (output en, wr_en, rd_en, flush, wr_data,
                    input  rd_data, full, empty, count);
    modport slave  (input  en, wr_en, rd_en, flush, wr_data,
                    output rd_data, full, empty, count);
endinterface

// File: rtl/cordic_seq_fifo.sv
// Sample buffer: synchronous write and pop, head word visible combinationally,
// pointers wrap modulo DEPTH, everything frozen while en is low.
module cordic_seq_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input logic                    clock,
    input logic                    reset,
    cordic_ppl_sequencer_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr, do_rd;

    assign do_wr = bus.en && bus.wr_en && !bus.flush && (count_q != CW'(DEPTH));
    assign do_rd = bus.en && bus.rd_en && !bus.flush && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.en && bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.rd_data = mem_q[rd_ptr_q];
    assign bus.full    = (count_q == CW'(DEPTH));
    assign bus.empty   = (count_q == '0);
    assign bus.count   = count_q;

endmodule

// File: rtl/cordic_ppl_sequencer.sv
// Nios II custom-instruction sequencer: buffers samples, streams them into a
// pipelined function unit and returns the accumulated result.
module cordic_ppl_sequencer
    import cordic_seq_pkg::*;
#(
    parameter int unsigned LATENCY = 17,
    parameter int unsigned DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        fu_clk_en,
    output logic        fu_start,
    output logic [31:0] fu_dataa,
    output logic [31:0] fu_datab,
    input  logic [31:0] fu_result
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    cordic_ppl_sequencer_if #(.DEPTH(DEPTH)) fifo_bus ();

    cordic_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .bus   (fifo_bus.slave)
    );

    state_e             state_q, state_d;
    logic [31:0]        result_q, result_d;
    logic               done_q, done_d;
    logic               fu_start_q, fu_start_d;
    logic               fu_tag_q, fu_tag_d;
    logic [31:0]        fu_dataa_q, fu_dataa_d;
    logic [31:0]        fu_datab_q, fu_datab_d;
    logic [CW-1:0]      remain_q, remain_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] tag_q, tag_d;
    logic               wr_en_c, rd_en_c, flush_c;
    logic [6:0]         cnt7;
    logic               unused_datab;

    assign unused_datab = ^datab;
    assign cnt7         = 7'(fifo_bus.count);

    assign fifo_bus.en      = clk_en;
    assign fifo_bus.wr_en   = wr_en_c;
    assign fifo_bus.rd_en   = rd_en_c;
    assign fifo_bus.flush   = flush_c;
    assign fifo_bus.wr_data = dataa;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        done_d     = done_q;
        fu_start_d = fu_start_q;
        fu_tag_d   = fu_tag_q;
        fu_dataa_d = fu_dataa_q;
        fu_datab_d = fu_datab_q;
        remain_d   = remain_q;
        vld_d      = vld_q;
        tag_d      = tag_q;
        wr_en_c    = 1'b0;
        rd_en_c    = 1'b0;
        flush_c    = 1'b0;

        if (clk_en) begin
            done_d     = 1'b0;
            fu_start_d = 1'b0;
            fu_tag_d   = 1'b0;
            fu_datab_d = '0;
            // Tokens enter as the FU samples fu_start, so the tagged one leaves
            // the shift register exactly when its accumulated result is valid.
            vld_d = (vld_q << 1) | LATENCY'(fu_start_q);
            tag_d = (tag_q << 1) | LATENCY'(fu_tag_q);

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ACK;
                        done_d  = 1'b1;
                        case (op_e'(n))
                            OP_PUSH: begin
                                if (fifo_bus.full) begin
                                    result_d = count_word(cnt7) | (32'd1 << OVF_BIT);
                                end else begin
                                    wr_en_c  = 1'b1;
                                    result_d = 32'(cnt7) + 32'd1;
                                end
                            end
                            OP_STATUS: result_d = count_word(cnt7);
                            OP_FLUSH: begin
                                flush_c  = 1'b1;
                                result_d = '0;
                            end
                            OP_RUN: begin
                                result_d = '0;
                                if (!fifo_bus.empty) begin
                                    state_d    = S_ISSUE;
                                    done_d     = 1'b0;
                                    rd_en_c    = 1'b1;
                                    fu_start_d = 1'b1;
                                    fu_dataa_d = fifo_bus.rd_data;
                                    fu_datab_d = 32'h1;
                                    fu_tag_d   = (fifo_bus.count == CW'(1));
                                    remain_d   = fifo_bus.count - CW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_ACK: state_d = S_IDLE;
                S_ISSUE: begin
                    if (remain_q != '0) begin
                        rd_en_c    = 1'b1;
                        fu_start_d = 1'b1;
                        fu_dataa_d = fifo_bus.rd_data;
                        fu_tag_d   = (remain_q == CW'(1));
                        remain_d   = remain_q - CW'(1);
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (vld_q[LATENCY-1] && tag_q[LATENCY-1]) begin
                        result_d = fu_result;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            done_q     <= 1'b0;
            fu_start_q <= 1'b0;
            fu_tag_q   <= 1'b0;
            fu_dataa_q <= '0;
            fu_datab_q <= '0;
            remain_q   <= '0;
            vld_q      <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            done_q     <= done_d;
            fu_start_q <= fu_start_d;
            fu_tag_q   <= fu_tag_d;
            fu_dataa_q <= fu_dataa_d;
            fu_datab_q <= fu_datab_d;
            remain_q   <= remain_d;
            vld_q      <= vld_d;
            tag_q      <= tag_d;
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign fu_clk_en = clk_en;
    assign fu_start  = fu_start_q;
    assign fu_dataa  = fu_dataa_q;
    assign fu_datab  = fu_datab_q;

endmodule

// File: tb/tb_cordic_ppl_sequencer.sv
// Directed bench for cordic_ppl_sequencer with a latency-17 summing FU model.
module tb_cordic_ppl_sequencer;
    localparam int unsigned LAT = 17;
    localparam int unsigned DEP = 16;
    localparam logic [1:0] PUSH = 2'd0, RUN = 2'd1, STATUS = 2'd2, FLUSH = 2'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  n = 2'd0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
    logic        done;
    logic        fu_clk_en;
    logic        fu_start;
    logic [31:0] fu_dataa;
    logic [31:0] fu_datab;
    logic [31:0] fu_result;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    cordic_ppl_sequencer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clock     (clock),
        .reset     (reset),
        .clk_en    (clk_en),
        .start     (start),
        .n         (n),
        .dataa     (dataa),
        .datab     (datab),
        .result    (result),
        .done      (done),
        .fu_clk_en (fu_clk_en),
        .fu_start  (fu_start),
        .fu_dataa  (fu_dataa),
        .fu_datab  (fu_datab),
        .fu_result (fu_result)
    );

    // Single <-> double conversion for normal numbers and zero.
    function automatic logic [63:0] s2d(input logic [31:0] s);
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return d2s($realtobits($bitstoreal(s2d(a)) + $bitstoreal(s2d(b))));
    endfunction

    // FU model: result of the sample issued in cycle k appears in cycle k+LAT.
    logic [31:0] acc = '0;
    logic [31:0] pipe [LAT];
    logic [31:0] fu_next;
    assign fu_next   = (fu_datab == 32'h1) ? fu_dataa : fadd(acc, fu_dataa);
    assign fu_result = pipe[LAT-1];

    always @(posedge clock) begin
        if (fu_clk_en) begin
            if (fu_start) begin
                acc     <= fu_next;
                pipe[0] <= fu_next;
            end else begin
                pipe[0] <= acc;
            end
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    int          fs_cnt = 0;
    int          clr_cnt = 0;
    logic [31:0] clr_data = '0;
    always @(posedge clock) begin
        if (fu_clk_en && fu_start) begin
            fs_cnt <= fs_cnt + 1;
            if (fu_datab == 32'h1) begin
                clr_cnt  <= clr_cnt + 1;
                clr_data <= fu_dataa;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] d);
        start = 1'b1;
        n     = op;
        dataa = d;
        cyc();
        start = 1'b0;
        n     = 2'd0;
        dataa = '0;
    endtask

    task automatic cmd(input string tag, input logic [1:0] op, input logic [31:0] d,
                       input logic [31:0] exp);
        issue(op, d);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk(tag, result, exp);
        cyc();
    endtask

    task automatic wait_done(input int maxc, output int l);
        l = 1;
        while (!done && l < maxc) begin
            cyc();
            l++;
        end
    endtask

    initial begin
        int lat;
        int fs0;
        int dcnt;

        clk_en = 1'b1;
        repeat (3) cyc();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_fu_start", 32'(fu_start), 32'd0);
        chk("rst_fu_dataa", fu_dataa, 32'd0);
        chk("rst_fu_datab", fu_datab, 32'd0);
        reset = 1'b1;
        cyc();

        cmd("push1", PUSH, 32'h41c80000, 32'd1);
        cmd("push2", PUSH, 32'h00000000, 32'd2);
        cmd("push3", PUSH, 32'h42480000, 32'd3);
        cmd("push4", PUSH, 32'h42960000, 32'd4);

        fs0 = fs_cnt;
        issue(RUN, '0);
        wait_done(100, lat);
        chk("run_latency", 32'(lat), 32'd22);
        chk("run_result", result, 32'h43160000);
        chk("run_clear_count", 32'(clr_cnt), 32'd1);
        chk("run_clear_sample", clr_data, 32'h41c80000);
        chk("run_issues", 32'(fs_cnt - fs0), 32'd4);
        cyc();
        chk("run_done_one_cycle", 32'(done), 32'd0);
        cmd("status_after_run", STATUS, '0, 32'd0);

        fs0 = fs_cnt;
        cmd("run_empty", RUN, '0, 32'd0);
        repeat (5) cyc();
        chk("run_empty_no_issue", 32'(fs_cnt - fs0), 32'd0);

        for (int i = 0; i < 16; i++)
            cmd($sformatf("fill%0d", i + 1), PUSH, 32'h3f800000 + 32'(i), 32'(i + 1));
        cmd("push_full", PUSH, 32'h40000000, 32'h80000010);
        cmd("status_full", STATUS, '0, 32'h00000010);
        cmd("flush", FLUSH, '0, 32'd0);
        cmd("status_flushed", STATUS, '0, 32'd0);

        cmd("spush1", PUSH, 32'h41c80000, 32'd1);
        cmd("spush2", PUSH, 32'h00000000, 32'd2);
        cmd("spush3", PUSH, 32'h42480000, 32'd3);
        cmd("spush4", PUSH, 32'h42960000, 32'd4);
        issue(RUN, '0);
        lat = 1;
        cyc();
        lat++;
        clk_en = 1'b0;
        repeat (3) begin
            cyc();
            lat++;
        end
        chk("stall_hold_fu_start", 32'(fu_start), 32'd1);
        chk("stall_no_done", 32'(done), 32'd0);
        clk_en = 1'b1;
        // A PUSH strobe while draining must be ignored.
        while (!done && lat < 100) begin
            start = (lat == 10);
            n     = PUSH;
            dataa = 32'h12345678;
            cyc();
            lat++;
        end
        start = 1'b0;
        chk("stall_latency", 32'(lat), 32'd25);
        chk("stall_result", result, 32'h43160000);
        chk("stall_clear_count", 32'(clr_cnt), 32'd2);
        cyc();
        cmd("status_after_stall", STATUS, '0, 32'd0);

        cmd("apush1", PUSH, 32'h41c80000, 32'd1);
        cmd("apush2", PUSH, 32'h42480000, 32'd2);
        issue(RUN, '0);
        repeat (6) cyc();
        reset = 1'b0;
        #1;
        chk("abort_fu_start", 32'(fu_start), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        cyc();
        reset = 1'b1;
        dcnt = 0;
        repeat (40) begin
            cyc();
            if (done) dcnt++;
        end
        chk("abort_no_done_pulse", 32'(dcnt), 32'd0);
        cmd("status_after_abort", STATUS, '0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cordic_ppl_sequencer.md
CORDIC_PPL_SEQUENCER -- requirements
Module: cordic_ppl_sequencer

Interface
REQ-001 The block SHALL have parameter LATENCY, default 17: issue-to-result latency of the attached pipelined function unit, in clk_en-qualified cycles.
REQ-002 The block SHALL have parameter DEPTH, default 16: sample buffer entries; power of two, 2..64.
REQ-003 The block SHALL have port clock, input, 1: single clock; all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port clk_en, input, 1: Nios II custom-instruction clock enable; all state frozen when low.
REQ-006 The block SHALL have port start, input, 1: one-cycle command strobe.
REQ-007 The block SHALL have port n, input, 2: opcode; 0 PUSH, 1 RUN, 2 STATUS, 3 FLUSH.
REQ-008 The block SHALL have port dataa, input, 32: IEEE-754 single sample for PUSH; otherwise ignored.
REQ-009 The block SHALL have port datab, input, 32: reserved, ignored.
REQ-010 The block SHALL have port result, output, 32: command result, valid while done=1.
REQ-011 The block SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 The block SHALL have port fu_clk_en, output, 1: function-unit clock enable, equal to clk_en.
REQ-013 The block SHALL have port fu_start, output, 1: function-unit issue strobe.
REQ-014 The block SHALL have port fu_dataa, output, 32: sample to function unit.
REQ-015 The block SHALL have port fu_datab, output, 32: 1 = clear accumulator with this sample, 0 = accumulate.
REQ-016 The block SHALL have port fu_result, input, 32: function-unit accumulated output.

Function
REQ-017 The FSM SHALL have states IDLE, ACK, ISSUE, DRAIN, DONE; start is sampled only in IDLE with clk_en=1.
REQ-018 PUSH SHALL write dataa to the buffer tail, go to ACK, and pulse done next cycle with result = new fill count.
REQ-019 PUSH when full SHALL drop the sample, leave the count unchanged, and return result = {1'b1, 25'b0, count}.
REQ-020 STATUS SHALL pulse done next cycle with result = {1'b0, 24'b0, busy_flag=0, count[5:0]} without altering state.
REQ-021 FLUSH SHALL empty the buffer and pulse done next cycle with result = 0.
REQ-022 RUN with count=0 SHALL pulse done next cycle with result = 0 and never assert fu_start.
REQ-023 RUN with count=N>0 SHALL enter ISSUE and pop one sample per enabled cycle for N consecutive cycles, driving fu_start=1 and fu_dataa=sample.
REQ-024 In ISSUE, fu_datab SHALL be 32'h1 on the first issued sample and 32'h0 on the rest; outside ISSUE, fu_start=0 and fu_datab=0.
REQ-025 A LATENCY-bit valid shift register SHALL track issued tokens, with the last token tagged; after the final issue the FSM goes to DRAIN.
REQ-026 When the tagged token reaches the shift-register output, fu_result SHALL be captured and the FSM goes to DONE; done=1 for one cycle with result = captured value.
REQ-027 RUN total latency SHALL be exactly N+LATENCY+1 enabled cycles from the start cycle to the done cycle.
REQ-028 start outside IDLE SHALL be ignored; no queuing.
REQ-029 clk_en=0 SHALL hold the FSM, buffer, pointers, shift register and outputs, and SHALL stretch every latency by the number of stalled cycles.
REQ-030 Buffer pointers SHALL wrap modulo DEPTH; count SHALL be held in clog2(DEPTH)+1 bits.
REQ-031 After RUN completes, the buffer SHALL be empty.

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, count=0, pointers=0, shift register=0, done=0, result=0, fu_start=0, fu_dataa=0, fu_datab=0.
REQ-033 Reset during ISSUE or DRAIN SHALL abort the operation; no done pulse SHALL occur, and tokens still in flight SHALL be discarded.

Structure
REQ-034 Opcode constants, FSM state encodings, and the overflow-flag bit position SHALL live in the shared package cordic_seq_pkg.
REQ-035 The sample buffer SHALL be the sub-module cordic_seq_fifo: synchronous write and read, with full and empty flags and count output.

Verification
REQ-036 PUSH 0x41c80000, 0x00000000, 0x42480000, 0x42960000 -> done after 1 cycle each; results 1, 2, 3, 4.
REQ-037 RUN with a latency-17 summing FU model -> fu_datab=1 only on 0x41c80000; done 22 cycles after start; result 0x43160000 (150.0).
REQ-038 Push 17 samples with DEPTH=16 -> the 17th result is 0x80000010; STATUS -> 0x00000010.
REQ-039 RUN on an empty buffer -> done after 1 cycle, result 0, fu_start never high.
REQ-040 Hold clk_en=0 for 3 cycles mid-ISSUE -> done arrives 3 cycles later with an unchanged result; reset during DRAIN -> no done pulse, and STATUS then returns 0.
